// File: rtl/dmem_arb_pkg.sv
// Shared types and grant-selection helper for the two-port data-memory arbiter.
// Port 0 is the CPU load/store port, port 1 the auxiliary (debug/DMA) requester.
package dmem_arb_pkg;

    typedef logic port_t;

    localparam port_t PORT_CPU = 1'b0;
    localparam port_t PORT_AUX = 1'b1;

    // Returns {gnt1, gnt0}. Under contention the previous winner keeps the
    // RAM until it has used up its burst allowance.
    function automatic logic [1:0] grant_f(
        input logic        req0,
        input logic        req1,
        input port_t       last,
        input int unsigned cnt,
        input int unsigned max_burst
    );
        logic [1:0] g;
        port_t      win;
        g   = 2'b00;
        win = (cnt < max_burst) ? last : ~last;
        if (req0 && req1) begin
            g = (win == PORT_AUX) ? 2'b10 : 2'b01;
        end else if (req0) begin
            g = 2'b01;
        end else if (req1) begin
            g = 2'b10;
        end
        return g;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester and RAM-side signals of the data-memory arbiter.
// The arbiter uses the slave view; the requesters plus RAM use the master view.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              gnt0;
    logic              gnt1;
    logic              rvalid0;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_wen;
    logic              mem_ren;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
               mem_addr, mem_wdata, mem_wen, mem_ren
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
               mem_addr, mem_wdata, mem_wen, mem_ren
    );
endinterface

// File: rtl/dmem_arb_sel.sv
// Grant selection: holds the last-winner and burst counter, produces the
// combinational grants. Grants are suppressed while reset is asserted.
module dmem_arb_sel
    import dmem_arb_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_req0,
    input  logic i_req1,
    output logic o_gnt0,
    output logic o_gnt1
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    port_t            r_last;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       w_gnt;
    port_t            w_port;

    always_comb begin
        w_gnt = 2'b00;
        if (rst_n) begin
            w_gnt = grant_f(i_req0, i_req1, r_last, 32'(r_cnt), 32'(MAX_BURST));
        end
        w_port = w_gnt[1] ? PORT_AUX : PORT_CPU;
    end

    assign o_gnt0 = w_gnt[0];
    assign o_gnt1 = w_gnt[1];

    // Counter saturates at MAX_BURST; a change of winner restarts it at 1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last <= PORT_CPU;
            r_cnt  <= '0;
        end else if (|w_gnt) begin
            if (w_port == r_last) begin
                if (r_cnt != CNT_W'(MAX_BURST)) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else begin
                r_last <= w_port;
                r_cnt  <= CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter sharing one single-port data RAM between the CPU and an
// auxiliary requester; routes the one-cycle read return back to the issuer.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    dmem_arbiter_if.slave bus
);

    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic [1:0]        r_rd_pend;

    dmem_arb_sel #(
        .MAX_BURST (MAX_BURST)
    ) u_sel (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_req0 (bus.req0),
        .i_req1 (bus.req1),
        .o_gnt0 (w_gnt0),
        .o_gnt1 (w_gnt1)
    );

    always_comb begin
        w_we    = 1'b0;
        w_addr  = '0;
        w_wdata = '0;
        if (w_gnt0) begin
            w_we    = bus.we0;
            w_addr  = bus.addr0;
            w_wdata = bus.wdata0;
        end else if (w_gnt1) begin
            w_we    = bus.we1;
            w_addr  = bus.addr1;
            w_wdata = bus.wdata1;
        end
    end

    assign bus.gnt0      = w_gnt0;
    assign bus.gnt1      = w_gnt1;
    assign bus.mem_addr  = w_addr;
    assign bus.mem_wdata = w_wdata;
    assign bus.mem_wen   = (w_gnt0 | w_gnt1) & w_we;
    assign bus.mem_ren   = (w_gnt0 | w_gnt1) & ~w_we;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_pend <= '0;
        end else begin
            r_rd_pend <= {w_gnt1 & ~bus.we1, w_gnt0 & ~bus.we0};
        end
    end

    // Gating with rst_n drops a read return that is in flight when reset hits.
    assign bus.rvalid0 = r_rd_pend[0] & rst_n;
    assign bus.rvalid1 = r_rd_pend[1] & rst_n;
    assign bus.rdata0  = bus.mem_rdata;
    assign bus.rdata1  = bus.mem_rdata;

endmodule
